data_bus_bridge: RTL and testbench
==================================

Name: data_bus_bridge

Overview:
Data-side memory bridge. Sits directly downstream of the processor's Memory stage and consumes its DataAddr/DataOut/ReadData/WriteData request. Decodes each request to one of three targets: a synchronous RAM with fixed read latency, a memory-mapped LED register, or a switch input port. Generates DataWaitreq so the processor stalls until read data is valid.

Parameters:
WORD_SIZE, 16, data/address width
RAM_ADDR_BITS, 12, RAM word-address width; RAM occupies 0x0000..(2^RAM_ADDR_BITS)-1
MEM_LATENCY, 2, RAM read latency in cycles (legal range 1..7)
LED_ADDR, 16'h1000, LED register address
SW_ADDR, 16'h3000, switch port address

Ports:
Clock  in  1  clock
Reset  in  1  reset
DataAddr  in  WORD_SIZE  request address from processor
DataOut  in  WORD_SIZE  write data from processor
ReadData  in  1  read request
WriteData  in  1  write request
DataIn  out  WORD_SIZE  read data to processor
DataWaitreq  out  1  stall request to processor
ram_addr  out  RAM_ADDR_BITS  RAM address
ram_wdata  out  WORD_SIZE  RAM write data
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_rdata  in  WORD_SIZE  RAM read data
SW  in  10  asynchronous switch inputs
LEDR  out  10  LED register
bus_error  out  1  sticky error flag

Behaviour:
- Reset: Reset is synchronous and active-high; clock is Clock. On reset: FSM=IDLE, latency counter=0, LEDR=0, bus_error=0, switch synchroniser flops=0. DataWaitreq, ram_we, ram_re and DataIn are combinational and evaluate to 0 in IDLE with no request.
- Request: req = ReadData | WriteData. The processor holds its request signals stable while DataWaitreq=1.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE, RAM read:
  - ram_re=1 and ram_addr=DataAddr[RAM_ADDR_BITS-1:0], combinational in the request cycle.
  - DataWaitreq=1 in the same cycle.
  - Latch the address, load counter=MEM_LATENCY-1.
  - Next state is WAIT if MEM_LATENCY>1, else DONE.
- WAIT: DataWaitreq=1, counter decrements each cycle. Move to DONE when counter=1.
- DONE: DataWaitreq=0, DataIn=ram_rdata. ram_rdata is valid exactly MEM_LATENCY cycles after the ram_re cycle. Next state is IDLE.
- Total RAM read: DataWaitreq high for exactly MEM_LATENCY cycles. The transaction completes in cycle MEM_LATENCY after request.
- Back-to-back reads: the cycle after DONE is IDLE. A new request is accepted there with no bubble beyond the FSM return.
- RAM write (IDLE): ram_we=1, ram_addr/ram_wdata driven from DataAddr/DataOut in the request cycle. DataWaitreq=0 (posted write). FSM stays IDLE.
- LED write: LEDR <= DataOut[9:0] at the clock edge. DataWaitreq=0.
- SW read: DataIn={6'b0, sw_sync}, where sw_sync is the SW value after a 2-flop synchroniser. DataWaitreq=0. Completes in the request cycle.
- LED read: returns {6'b0, LEDR}, no wait.
- Unmapped address: reads return 0, writes are dropped, DataWaitreq=0, bus_error<=1. bus_error stays set until reset.
- Illegal request (ReadData & WriteData both 1): executed as a write, and bus_error<=1.
- Request signals change during WAIT: ignored. The latched address is used and the transaction completes normally.
- ram_we and ram_re never assert in the same cycle. Neither asserts in WAIT or DONE.
- Reset mid-transaction: FSM returns to IDLE, DataWaitreq drops in the cycle after the reset edge, and the pending read is discarded.
- DataIn=0 whenever no read completes in the current cycle.

Optional Feature:
- Macro: DATA_BUS_STATS_EN.
- When defined: a 16-bit saturating stall counter increments on every cycle with DataWaitreq=1 and holds at 16'hFFFF. It is readable at address 16'h2000 with no wait. A write to 16'h2000 clears it to 0. Reset clears it.
- When undefined: 16'h2000 is unmapped (read returns 0, bus_error set) and no counter logic exists.

Test Plan:
1. Write 0x1234 to 0x0040 (ram_we=1 one cycle, Waitreq=0), then read 0x0040 with MEM_LATENCY=2 -> ram_re=1 in cycle 0, Waitreq=1 in cycles 0-1, DataIn=0x1234 and Waitreq=0 in cycle 2.
2. Write 0x03FF to 0x1000 -> LEDR=0x3FF next cycle; read 0x1000 -> DataIn=0x03FF, no wait.
3. SW=10'h155, wait 2 cycles, read 0x3000 -> DataIn=0x0155 in the same cycle, Waitreq=0.
4. Read 0x5000 -> DataIn=0, bus_error=1 and stays set after two further legal accesses; Reset -> bus_error=0, LEDR=0.
5. Assert Reset in cycle 1 of a MEM_LATENCY=3 read -> FSM IDLE, Waitreq=0 next cycle; a following read to 0x0010 returns that address's RAM data after 3 wait cycles.
6. DATA_BUS_STATS_EN defined: two RAM reads at MEM_LATENCY=2, then read 0x2000 -> DataIn=4; write 0x2000, read again -> 0.

Source files
------------

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: data-side memory bridge between the processor Memory stage
// and a fixed-latency synchronous RAM, an LED register and a switch input port.
// Optional feature: define DATA_BUS_STATS_EN to add a saturating stall counter
// at address 16'h2000 (read returns the count, write clears it).
module data_bus_bridge #(
  parameter int unsigned          WORD_SIZE     = 16,
  parameter int unsigned          RAM_ADDR_BITS = 12,
  parameter int unsigned          MEM_LATENCY   = 2,
  parameter logic [WORD_SIZE-1:0] LED_ADDR      = 16'h1000,
  parameter logic [WORD_SIZE-1:0] SW_ADDR       = 16'h3000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [WORD_SIZE-1:0]     DataAddr,
  input  logic [WORD_SIZE-1:0]     DataOut,
  input  logic                     ReadData,
  input  logic                     WriteData,
  output logic [WORD_SIZE-1:0]     DataIn,
  output logic                     DataWaitreq,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [WORD_SIZE-1:0]     ram_wdata,
  output logic                     ram_we,
  output logic                     ram_re,
  input  logic [WORD_SIZE-1:0]     ram_rdata,
  input  logic [9:0]               SW,
  output logic [9:0]               LEDR,
  output logic                     bus_error
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IO_W  = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]               state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_next;
  logic [IO_W-1:0]          sw_meta, sw_sync;
  logic                     led_we;
  logic                     err_set;

  logic                     hit_ram, hit_led, hit_sw, hit_stats;
  logic [WORD_SIZE-1:0]     stats_val;

  assign hit_ram   = (DataAddr[WORD_SIZE-1:RAM_ADDR_BITS] == '0);
  assign hit_led   = (DataAddr == LED_ADDR);
  assign hit_sw    = (DataAddr == SW_ADDR);
  assign ram_wdata = DataOut;

`ifdef DATA_BUS_STATS_EN
  localparam int unsigned          STATS_W    = 16;
  localparam logic [WORD_SIZE-1:0] STATS_ADDR = WORD_SIZE'(16'h2000);

  logic [STATS_W-1:0] stall_cnt;
  logic               stats_clr;

  assign hit_stats = (DataAddr == STATS_ADDR);
  assign stats_val = WORD_SIZE'(stall_cnt);
  assign stats_clr = (state == IDLE) && WriteData && hit_stats;

  // Saturating count of stalled cycles; cleared by reset or a write to its address
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (DataWaitreq && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STATS_W'(1);
    end
  end
`else
  assign hit_stats = 1'b0;
  assign stats_val = '0;
`endif

  // Decode the request, drive the bus side and choose the next state
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    addr_next   = addr_q;
    DataIn      = '0;
    DataWaitreq = 1'b0;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    led_we      = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (ReadData && !WriteData) begin
          if (hit_ram) begin
            ram_re      = 1'b1;
            ram_addr    = DataAddr[RAM_ADDR_BITS-1:0];
            DataWaitreq = 1'b1;
            addr_next   = DataAddr[RAM_ADDR_BITS-1:0];
            cnt_next    = LAT_LOAD;
            state_next  = (MEM_LATENCY > 1) ? WAIT : DONE;
          end else if (hit_led) begin
            DataIn = WORD_SIZE'(LEDR);
          end else if (hit_sw) begin
            DataIn = WORD_SIZE'(sw_sync);
          end else if (hit_stats) begin
            DataIn = stats_val;
          end else begin
            err_set = 1'b1;
          end
        end else if (WriteData) begin
          // A simultaneous read strobe is flagged but the write still proceeds
          err_set = ReadData;
          if (hit_ram) begin
            ram_we   = 1'b1;
            ram_addr = DataAddr[RAM_ADDR_BITS-1:0];
          end else if (hit_led) begin
            led_we = 1'b1;
          end else if (!hit_sw && !hit_stats) begin
            err_set = 1'b1;
          end
        end
      end
      WAIT: begin
        DataWaitreq = 1'b1;
        cnt_next    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        DataIn     = ram_rdata;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, latency counter and latched read address
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      addr_q <= addr_next;
    end
  end

  // Memory-mapped LED register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      LEDR <= '0;
    end else if (led_we) begin
      LEDR <= DataOut[IO_W-1:0];
    end
  end

  // Sticky bus error flag, cleared only by reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus_error <= 1'b0;
    end else if (err_set) begin
      bus_error <= 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: randomized bench for data_bus_bridge with a transaction-level
// reference model; a second instance at read latency 3 covers reset mid-read.
`timescale 1ns/1ps
module tb_data_bus_bridge;

  localparam int ML  = 2;
  localparam int ML3 = 3;
`ifdef DATA_BUS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, ReadData, WriteData, DataWaitreq, ram_we, ram_re, bus_error;
  logic [15:0] DataAddr, DataOut, DataIn, ram_wdata, ram_rdata;
  logic [11:0] ram_addr;
  logic [9:0]  SW, LEDR;

  logic        Reset3, ReadData3, WriteData3, DataWaitreq3, ram_we3, ram_re3, bus_error3;
  logic [15:0] DataAddr3, DataOut3, DataIn3, ram_wdata3, ram_rdata3;
  logic [11:0] ram_addr3;
  logic [9:0]  SW3, LEDR3;

  data_bus_bridge #(.MEM_LATENCY(ML)) dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
    .DataWaitreq(DataWaitreq), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .SW(SW),
    .LEDR(LEDR), .bus_error(bus_error));

  data_bus_bridge #(.MEM_LATENCY(ML3)) dut3 (
    .Clock(Clock), .Reset(Reset3), .DataAddr(DataAddr3), .DataOut(DataOut3),
    .ReadData(ReadData3), .WriteData(WriteData3), .DataIn(DataIn3),
    .DataWaitreq(DataWaitreq3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_we(ram_we3), .ram_re(ram_re3), .ram_rdata(ram_rdata3), .SW(SW3),
    .LEDR(LEDR3), .bus_error(bus_error3));

  // Environment RAMs: data appears exactly N cycles after the read-enable cycle
  logic [15:0] ram_mem  [4096];
  logic [15:0] ram_mem3 [4096];
  logic [15:0] pipe  [ML];
  logic [15:0] pipe3 [ML3];

  always @(posedge Clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    pipe[0] <= ram_re ? ram_mem[ram_addr] : 16'hDEAD;
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[ML-1];

  always @(posedge Clock) begin
    if (ram_we3) ram_mem3[ram_addr3] <= ram_wdata3;
    pipe3[0] <= ram_re3 ? ram_mem3[ram_addr3] : 16'hDEAD;
    for (int i = 1; i < ML3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign ram_rdata3 = pipe3[ML3-1];

  // Reference model state
  logic [15:0] mmem [4096];
  logic [9:0]  m_leds;
  bit          m_err;
  int          m_stall;
  int          cyc, rst_cyc;
  logic [9:0]  sw_at [1024];
  bit          sw_rand;

  typedef struct packed {
    bit          chk;
    bit          wt;
    logic [15:0] din;
    bit          re;
    bit          we;
    bit          chk_addr;
    logic [11:0] addr;
    bit          chk_wdata;
    logic [15:0] wdata;
    logic [9:0]  leds;
    bit          err;
  } exp_t;
  exp_t exp;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Per-cycle comparison of the main instance against the model
  always @(negedge Clock) begin
    if (exp.chk) begin
      check("waitreq", 32'(DataWaitreq), 32'(exp.wt));
      check("datain",  32'(DataIn),      32'(exp.din));
      check("ram_re",  32'(ram_re),      32'(exp.re));
      check("ram_we",  32'(ram_we),      32'(exp.we));
      check("ledr",    32'(LEDR),        32'(exp.leds));
      check("bus_err", 32'(bus_error),   32'(exp.err));
      if (exp.chk_addr)  check("ram_addr",  32'(ram_addr),  32'(exp.addr));
      if (exp.chk_wdata) check("ram_wdata", 32'(ram_wdata), 32'(exp.wdata));
    end
  end

  function automatic logic [9:0] exp_sw();
    if (cyc - 2 > rst_cyc) return sw_at[(cyc - 2) % 1024];
    return '0;
  endfunction

  task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    Reset = 1'b0; ReadData = rd; WriteData = wr; DataAddr = a; DataOut = d;
    if (sw_rand) SW = 10'($urandom);
    sw_at[cyc % 1024] = SW;
    exp = '0;
    exp.chk  = 1'b1;
    exp.leds = m_leds;
    exp.err  = m_err;
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) begin
      m_leds = '0; m_err = 1'b0; m_stall = 0; rst_cyc = cyc;
    end else if (exp.wt && m_stall < 65535) begin
      m_stall++;
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      Reset = 1'b1;
      exp.chk = 1'b0;
      tick();
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    tick();
  endtask

  // One processor transaction; rst_at aborts a RAM read with reset in that cycle
  task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input int rst_at = -1, input bit lit_en = 1'b0,
                        input logic [15:0] lit = 16'h0);
    bit in_ram, err_n;
    in_ram = (int'(a) < 4096);
    if (rd && !wr && in_ram) begin
      for (int k = 0; k <= ML; k++) begin
        if (k == rst_at) begin
          drive(1'b0, 1'b0, 16'h0, 16'h0);
          Reset = 1'b1;
          exp.chk = 1'b0;
          tick();
          return;
        end
        if (k > 0 && k < ML && $urandom_range(0, 1) == 1)
          drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        else
          drive(1'b1, 1'b0, a, d);
        exp.wt = (k < ML);
        exp.re = (k == 0);
        if (k == 0) begin exp.chk_addr = 1'b1; exp.addr = a[11:0]; end
        if (k == ML) begin
          exp.din = mmem[a[11:0]];
          if (lit_en) begin #2; check("lit_ram_din", 32'(DataIn), 32'(lit)); end
        end
        tick();
      end
      return;
    end
    drive(rd, wr, a, d);
    err_n = rd && wr;
    if (wr) begin
      if (in_ram) begin
        exp.we = 1'b1; exp.chk_addr = 1'b1; exp.addr = a[11:0];
        exp.chk_wdata = 1'b1; exp.wdata = d;
      end else if (a != 16'h1000 && a != 16'h3000 && !(STATS && a == 16'h2000)) begin
        err_n = 1'b1;
      end
    end else if (rd) begin
      if (a == 16'h1000)                exp.din = {6'b0, m_leds};
      else if (a == 16'h3000)           exp.din = {6'b0, exp_sw()};
      else if (STATS && a == 16'h2000)  exp.din = 16'(m_stall);
      else                              err_n = 1'b1;
    end
    if (lit_en) begin #2; check("lit_din", 32'(DataIn), 32'(lit)); end
    tick();
    if (wr && in_ram) mmem[a[11:0]] = d;
    if (wr && a == 16'h1000) m_leds = d[9:0];
    if (wr && STATS && a == 16'h2000) m_stall = 0;
    m_err = m_err | err_n;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return 16'($urandom_range(0, 63));
      1:       return 16'($urandom_range(0, 4095));
      2:       return 16'h1000;
      3:       return 16'h3000;
      4:       return 16'h2000;
      5:       return 16'($urandom_range(16'h4000, 16'hFFFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i]  = 16'hA000 ^ 16'(i);
      ram_mem3[i] = 16'hA000 ^ 16'(i);
      mmem[i]     = 16'hA000 ^ 16'(i);
    end
    exp = '0; m_leds = '0; m_err = 1'b0; m_stall = 0; cyc = 0; rst_cyc = 0;
    sw_rand = 1'b1; SW = '0;
    Reset3 = 1'b1; ReadData3 = 1'b0; WriteData3 = 1'b0;
    DataAddr3 = '0; DataOut3 = '0; SW3 = '0;

    do_reset(2);
    Reset3 = 1'b0;
    check("reset_ledr", 32'(LEDR), 32'h0);
    check("reset_err",  32'(bus_error), 32'h0);
    idle();

    // RAM write then latency-2 read
    access(1'b0, 1'b1, 16'h0040, 16'h1234);
    access(1'b1, 1'b0, 16'h0040, 16'h0, -1, 1'b1, 16'h1234);

    // LED write and readback
    access(1'b0, 1'b1, 16'h1000, 16'h03FF);
    check("lit_ledr", 32'(LEDR), 32'h3FF);
    access(1'b1, 1'b0, 16'h1000, 16'h0, -1, 1'b1, 16'h03FF);

    // Synchronised switch read
    sw_rand = 1'b0; SW = 10'h155;
    idle(); idle();
    access(1'b1, 1'b0, 16'h3000, 16'h0, -1, 1'b1, 16'h0155);
    sw_rand = 1'b1;

    // Unmapped read, sticky error, reset clears
    access(1'b1, 1'b0, 16'h5000, 16'h0, -1, 1'b1, 16'h0000);
    check("lit_err_set", 32'(bus_error), 32'h1);
    access(1'b1, 1'b0, 16'h1000, 16'h0);
    access(1'b0, 1'b1, 16'h0044, 16'hBEEF);
    check("lit_err_sticky", 32'(bus_error), 32'h1);
    do_reset(1);
    check("lit_err_clr", 32'(bus_error), 32'h0);
    check("lit_led_clr", 32'(LEDR), 32'h0);

    // Reset in cycle 1 of a latency-3 read, then a clean read of 0x0010
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    ReadData3 = 1'b1; DataAddr3 = 16'h0020;
    #2; check("l3_wait_c0", 32'(DataWaitreq3), 32'h1); check("l3_re_c0", 32'(ram_re3), 32'h1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    Reset3 = 1'b1; ReadData3 = 1'b0;
    #2; check("l3_wait_c1", 32'(DataWaitreq3), 32'h1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
    Reset3 = 1'b0;
    #2; check("l3_wait_after_rst", 32'(DataWaitreq3), 32'h0);
    check("l3_din_after_rst", 32'(DataIn3), 32'h0);
    tick();
    for (int k = 0; k <= ML3; k++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      ReadData3 = 1'b1; DataAddr3 = 16'h0010;
      #2;
      if (k < ML3) check("l3_wait", 32'(DataWaitreq3), 32'h1);
      else begin
        check("l3_wait_done", 32'(DataWaitreq3), 32'h0);
        check("l3_din_done",  32'(DataIn3), 32'hA010);
      end
      tick();
    end
    ReadData3 = 1'b0;

    // Stall statistics register
    do_reset(1);
`ifdef DATA_BUS_STATS_EN
    access(1'b1, 1'b0, 16'h0001, 16'h0);
    access(1'b1, 1'b0, 16'h0002, 16'h0);
    access(1'b1, 1'b0, 16'h2000, 16'h0, -1, 1'b1, 16'd4);
    access(1'b0, 1'b1, 16'h2000, 16'h0);
    access(1'b1, 1'b0, 16'h2000, 16'h0, -1, 1'b1, 16'd0);
`else
    access(1'b1, 1'b0, 16'h2000, 16'h0, -1, 1'b1, 16'h0000);
    check("lit_stats_unmapped", 32'(bus_error), 32'h1);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int kind;
      bit rd, wr;
      logic [15:0] a;
      kind = int'($urandom_range(0, 19));
      a = rand_addr();
      if (kind == 0) begin
        do_reset(1);
      end else if (kind < 3) begin
        idle();
      end else begin
        rd = (kind < 11) || (kind == 19);
        wr = (kind >= 11);
        if (rd && !wr && int'(a) < 4096 && $urandom_range(0, 9) == 0)
          access(rd, wr, a, 16'($urandom), int'($urandom_range(1, ML)));
        else
          access(rd, wr, a, 16'($urandom));
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
